// File: rtl/mrav_bus_arbiter.sv
// Round-robin multi-master / multi-slave bus arbiter for mrav_soc, one transaction in flight.
// Optional slave timeout enabled by defining MRAV_BUS_TIMEOUT_EN.
module mrav_bus_arbiter #(
    parameter int N_MASTERS      = 2,
    parameter int N_SLAVES       = 4,
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 8,
    parameter int REGION_SHIFT   = 12,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [N_MASTERS-1:0]             m_read,
    input  logic [N_MASTERS-1:0]             m_write,
    input  logic [N_MASTERS*ADDR_WIDTH-1:0]  m_addr,
    input  logic [N_MASTERS*DATA_WIDTH-1:0]  m_wdata,
    output logic [DATA_WIDTH-1:0]            m_rdata,
    output logic [N_MASTERS-1:0]             m_read_done,
    output logic [N_MASTERS-1:0]             m_write_done,
    output logic [N_MASTERS-1:0]             m_err,
    output logic [N_SLAVES-1:0]              s_read,
    output logic [N_SLAVES-1:0]              s_write,
    output logic [ADDR_WIDTH-1:0]            s_addr,
    output logic [DATA_WIDTH-1:0]            s_wdata,
    input  logic [N_SLAVES*DATA_WIDTH-1:0]   s_rdata,
    input  logic [N_SLAVES-1:0]              s_read_done,
    input  logic [N_SLAVES-1:0]              s_write_done,
    output logic                             busy
);

    localparam int MW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    localparam int SW = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;

    if (N_MASTERS < 1 || N_MASTERS > 8 || N_SLAVES < 1 || N_SLAVES > 16 ||
        TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_params
        $error("mrav_bus_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [MW-1:0]           ptr_q, ptr_d;
    logic [MW-1:0]           gnt_q, gnt_d;
    logic                    wr_q, wr_d;
    logic                    err_q, err_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [SW-1:0]           sel_q, sel_d;
`ifdef MRAV_BUS_TIMEOUT_EN
    logic [15:0]             cnt_q, cnt_d;
`endif

    // Arbitration: first requester at or after ptr_q, wrapping modulo N_MASTERS.
    logic                    req_found;
    logic [MW-1:0]           req_idx;
    logic [MW-1:0]           ptr_nxt;
    logic                    req_wr;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic [DATA_WIDTH-1:0]   req_wdata;
    logic [ADDR_WIDTH-1:0]   req_region;
    logic                    req_mapped;

    always_comb begin
        req_found = 1'b0;
        req_idx   = '0;
        ptr_nxt   = ptr_q;
        for (int k = 0; k < N_MASTERS; k++) begin
            for (int i = 0; i < N_MASTERS; i++) begin
                if (!req_found && (m_read[i] || m_write[i]) &&
                    i == (int'(ptr_q) + k) % N_MASTERS) begin
                    req_found = 1'b1;
                    req_idx   = MW'(i);
                    ptr_nxt   = MW'((i + 1) % N_MASTERS);
                end
            end
        end
    end

    // Write wins when a master raises both m_read and m_write.
    always_comb begin
        req_wr    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (req_idx == MW'(i)) begin
                req_wr    = m_write[i];
                req_addr  = m_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                req_wdata = m_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        req_region = req_addr >> REGION_SHIFT;
        req_mapped = (req_region < ADDR_WIDTH'(N_SLAVES));
    end

    // Only the selected slave's done of the matching type can end ACCESS.
    logic                    done_match;
    logic [DATA_WIDTH-1:0]   sel_rdata;

    always_comb begin
        done_match = 1'b0;
        sel_rdata  = '0;
        for (int s = 0; s < N_SLAVES; s++) begin
            if (sel_q == SW'(s)) begin
                done_match = wr_q ? s_write_done[s] : s_read_done[s];
                sel_rdata  = s_rdata[s*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        wr_d    = wr_q;
        err_d   = err_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        sel_d   = sel_q;
`ifdef MRAV_BUS_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req_found) begin
                    gnt_d   = req_idx;
                    ptr_d   = ptr_nxt;
                    wr_d    = req_wr;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    sel_d   = SW'(req_region);
                    rdata_d = '0;
                    err_d   = !req_mapped;
                    state_d = req_mapped ? S_ACCESS : S_RESP;
`ifdef MRAV_BUS_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            S_ACCESS: begin
`ifdef MRAV_BUS_TIMEOUT_EN
                cnt_d = cnt_q + 16'd1;
`endif
                if (done_match) begin
                    rdata_d = wr_q ? '0 : sel_rdata;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end
`ifdef MRAV_BUS_TIMEOUT_EN
                else if (cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end
`endif
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            sel_q   <= sel_d;
        end
    end

`ifdef MRAV_BUS_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    // Handshake: masters hold m_read/m_write until their one-cycle done pulse; slave
    // strobes are levels decoded from state_q, so they drop as soon as reset asserts.
    always_comb begin
        s_read       = '0;
        s_write      = '0;
        m_read_done  = '0;
        m_write_done = '0;
        m_err        = '0;
        for (int s = 0; s < N_SLAVES; s++) begin
            if (state_q == S_ACCESS && sel_q == SW'(s)) begin
                s_read[s]  = !wr_q;
                s_write[s] = wr_q;
            end
        end
        for (int i = 0; i < N_MASTERS; i++) begin
            if (state_q == S_RESP && gnt_q == MW'(i)) begin
                m_read_done[i]  = !wr_q;
                m_write_done[i] = wr_q;
                m_err[i]        = err_q;
            end
        end
        m_rdata = (state_q == S_RESP) ? rdata_q : '0;
        s_addr  = addr_q;
        s_wdata = wdata_q;
        busy    = (state_q != S_IDLE);
    end

endmodule

// File: doc/mrav_bus_arbiter.md
Name: mrav_bus_arbiter

Overview:
Parametrised multi-master, multi-slave successor to the single-core mrav bus. Arbitrates N_MASTERS requesters (cores, DMA, debug) round-robin and decodes each address to one of N_SLAVES regions. Carries the read/write and read_done/write_done handshake end to end, one transaction in flight. Adds error signalling for unmapped addresses and an optional slave timeout. Sits between masters and peripherals in mrav_soc.

Parameters:
N_MASTERS, 2, number of requesting masters (1..8)
N_SLAVES, 4, number of decoded slave regions (1..16)
ADDR_WIDTH, 16, address width
DATA_WIDTH, 8, data width
REGION_SHIFT, 12, slave index = addr >> REGION_SHIFT
TIMEOUT_CYCLES, 255, slave wait limit (used only with timeout feature)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
m_read  in  N_MASTERS  per-master read request, level
m_write  in  N_MASTERS  per-master write request, level
m_addr  in  N_MASTERS*ADDR_WIDTH  packed addresses, master i at [i*ADDR_WIDTH +: ADDR_WIDTH]
m_wdata  in  N_MASTERS*DATA_WIDTH  packed write data
m_rdata  out  DATA_WIDTH  read data, shared, valid in the m_read_done cycle
m_read_done  out  N_MASTERS  one-cycle read completion pulse
m_write_done  out  N_MASTERS  one-cycle write completion pulse
m_err  out  N_MASTERS  error flag, valid only with a done pulse
s_read  out  N_SLAVES  slave read strobe, level until slave done
s_write  out  N_SLAVES  slave write strobe, level until slave done
s_addr  out  ADDR_WIDTH  registered full address of the current transaction
s_wdata  out  DATA_WIDTH  registered write data
s_rdata  in  N_SLAVES*DATA_WIDTH  packed slave read data
s_read_done  in  N_SLAVES  slave read completion
s_write_done  in  N_SLAVES  slave write completion
busy  out  1  high when the FSM is not in IDLE

Behaviour:
- Reset: all outputs 0, FSM in IDLE, round-robin pointer 0 (master 0 has top priority), all registers cleared. Reset mid-transaction aborts it with no done pulse. Slave strobes drop asynchronously.
- States: IDLE, ACCESS, RESP.
- IDLE: request_i = m_read[i] | m_write[i]. Grant the first requester at or after ptr, modulo N_MASTERS. Register master index, op, addr, wdata, and slave index sel = addr >> REGION_SHIFT.
  - sel < N_SLAVES: go to ACCESS.
  - sel >= N_SLAVES: go directly to RESP with err=1, rdata=0.
  - Set ptr = granted+1 mod N_MASTERS.
- Same master asserting both m_read and m_write: write wins.
- ACCESS: hold s_read[sel] or s_write[sel], s_addr, and s_wdata stable. Ignore done inputs from non-selected slaves and done of the wrong type. On the matching done, capture s_rdata[sel] (reads) and go to RESP.
- RESP: pulse m_read_done or m_write_done of the granted master for exactly one cycle. Drive m_rdata and m_err in that cycle only; 0 otherwise. Next state IDLE.
- Latency: request seen in IDLE at cycle 0, strobe at cycle 1. Slave done at cycle k gives master done at cycle k+1. Unmapped access gives done at cycle 1. Minimum 2-cycle turnaround before the next grant.
- Request dropped by a master after grant: the transaction still completes and the done pulse is still issued.
- A master must hold its request until done. A request still high in the IDLE cycle after done is a new transaction.
- Fairness: with all masters continuously requesting, grants rotate 0,1,...,N_MASTERS-1,0.
- N_MASTERS=1: the arbiter degenerates to a pass-through with the same timing.

Optional Feature:
MRAV_BUS_TIMEOUT_EN:
- Defined: an 8..16-bit counter clears on entry to ACCESS and increments each ACCESS cycle. When the count reaches TIMEOUT_CYCLES with no slave done, drop the strobe and go to RESP with err=1, rdata=0. A slave done arriving in the same cycle as the timeout wins (no error).
- Undefined: no counter; ACCESS waits indefinitely.

Test Plan:
- Single read: master 0 reads 0x1004, slave 1 returns 0x5A after 3 cycles of strobe -> s_read[1] high cycles 1-3, m_read_done[0] pulse at cycle 4, m_rdata=0x5A, m_err=0.
- Write: master 1 writes 0xC3 to 0x2010 -> s_write[2]=1, s_addr=0x2010, s_wdata=0xC3 until s_write_done, then m_write_done[1] one cycle, m_err=0.
- Round-robin: both masters request continuously; slaves answer with done in the first strobe cycle -> grants 0,1,0,1; no master granted twice in a row.
- Unmapped: read 0x5000 with N_SLAVES=4 -> no slave strobe, m_read_done and m_err at cycle 1, m_rdata=0.
- Reset mid-ACCESS: assert rst while s_write[0] is high -> strobe drops immediately, no done pulse, busy=0, next grant goes to master 0.
- Timeout (MRAV_BUS_TIMEOUT_EN, TIMEOUT_CYCLES=8): slave never answers -> strobe for 8 cycles, then done with m_err=1, rdata=0; a slave done in cycle 8 -> m_err=0.
